// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared constants and control state type for the UART echo SoC
package soc_pkg;

  localparam int BANNER_LEN = 4;
  localparam int BANNER_IW  = 2;

  localparam logic [7:0] BANNER_0 = 8'h4F;
  localparam logic [7:0] BANNER_1 = 8'h4B;
  localparam logic [7:0] BANNER_2 = 8'h0D;
  localparam logic [7:0] BANNER_3 = 8'h0A;

  typedef enum logic {
    ST_BANNER,
    ST_ECHO
  } ctrl_state_t;

  function automatic logic [7:0] banner_byte(input logic [BANNER_IW-1:0] idx);
    case (idx)
      2'd0:    banner_byte = BANNER_0;
      2'd1:    banner_byte = BANNER_1;
      2'd2:    banner_byte = BANNER_2;
      default: banner_byte = BANNER_3;
    endcase
  endfunction

endpackage

// File: rtl/soc_uart.sv
// rtl/soc_uart.sv - 8N1 UART receive and transmit engines sharing one bit period
module soc_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_fall, rx_half, rx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_half = (rx_cnt == HALF_M1);
  assign rx_last = (rx_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_fall) rx_next = R_START;
      R_START: if (rx_half) rx_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_last && rx_bit == 3'd7) rx_next = R_STOP;
      R_STOP:  if (rx_last) rx_next = rx_s2 ? R_IDLE : R_WAIT;
      R_WAIT:  if (rx_s2) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    rx_valid     = (rx_state == R_STOP) && rx_last && rx_s2;
    rx_frame_err = (rx_state == R_STOP) && rx_last && !rx_s2;
    rx_data      = rx_shift;
  end

  // Counter restarts on every state change so each phase measures from its own entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state != rx_next || rx_last)
        rx_cnt <= '0;
      else if (rx_state == R_START || rx_state == R_DATA || rx_state == R_STOP)
        rx_cnt <= rx_cnt + 1'b1;
      else
        rx_cnt <= '0;
      if (rx_state == R_START)
        rx_bit <= '0;
      else if (rx_state == R_DATA && rx_last) begin
        rx_bit   <= rx_bit + 1'b1;
        rx_shift <= {rx_s2, rx_shift[7:1]};
      end
    end
  end

  logic [8:0]    tx_shift;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic          tx_act, tx_last;

  // Busy drops in the final stop-bit cycle so a queued byte follows with no gap.
  assign tx_last = tx_act && (tx_cnt == LAST) && (tx_bit == 4'd9);
  assign tx_busy = tx_act && !tx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      tx_act   <= 1'b0;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
    end else if (tx_start && !tx_busy) begin
      tx       <= 1'b0;
      tx_act   <= 1'b1;
      tx_shift <= {1'b1, tx_data};
      tx_bit   <= '0;
      tx_cnt   <= '0;
    end else if (tx_act) begin
      if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_act <= 1'b0;
        end else begin
          tx       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc.sv
// rtl/soc.sv - UART echo SoC: banner on reset, then echoes received bytes and shows the last one
module soc
  import soc_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic       clk,
  input  logic       reset_i,
  output logic [7:0] display_o,
  input  logic       rx_i,
  output logic       tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_frame_err, tx_start, tx_busy;

  soc_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk          (clk),
    .rst_n        (reset_i),
    .rx           (rx_i),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .tx           (tx_o)
  );

  ctrl_state_t          state, state_next;
  logic [BANNER_IW-1:0] banner_idx;
  logic [7:0]           hold_q;
  logic                 hold_full, rx_accept, hold_take;

  assign rx_accept = rx_valid && !rx_frame_err;
  assign hold_take = (state == ST_ECHO) && tx_start;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state <= ST_BANNER;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_BANNER && tx_start && banner_idx == BANNER_IW'(BANNER_LEN - 1))
      state_next = ST_ECHO;
  end

  always_comb begin
    tx_start = 1'b0;
    tx_data  = banner_byte(banner_idx);
    case (state)
      ST_BANNER: tx_start = !tx_busy;
      ST_ECHO: begin
        tx_start = !tx_busy && hold_full;
        tx_data  = hold_q;
      end
      default: tx_start = 1'b0;
    endcase
  end

  // A fresh byte wins over a same-cycle TX load, so the register stays full.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      banner_idx <= '0;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      display_o  <= '0;
    end else begin
      if (state == ST_BANNER && tx_start)
        banner_idx <= banner_idx + 1'b1;
      if (rx_accept) begin
        hold_q    <= rx_data;
        hold_full <= 1'b1;
        display_o <= rx_data;
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soc.sv
// tb/tb_soc.sv - randomized self-checking bench for the UART echo SoC
module tb_soc;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       tx_o;
  logic [7:0] display_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int tx_q[$];
  int tx_t[$];
  int tx_bad = 0;
  int disp_t = 0;
  logic [7:0] exp_disp = 8'h00;
  int banner[4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

  soc #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .display_o (display_o),
    .rx_i      (rx_i),
    .tx_o      (tx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder for tx_o: samples each bit near its middle and logs byte plus start cycle.
  initial begin : tx_monitor
    int first;
    int off;
    int k;
    bit busy;
    logic prev;
    logic [9:0] fr;
    busy = 0; prev = 1'b1; first = 0; fr = '0;
    forever begin
      @(negedge clk);
      if (reset_i !== 1'b1) begin
        busy = 0; prev = 1'b1;
      end else if (!busy) begin
        if (prev === 1'b1 && tx_o === 1'b0) begin
          busy = 1; first = cyc;
        end
        prev = tx_o;
      end else begin
        off = cyc - first;
        if (off >= 4 && (off - 4) % 10 == 0) begin
          k = (off - 4) / 10;
          fr[k] = tx_o;
          if (k == 9) begin
            busy = 0;
            if (fr[0] == 1'b0 && fr[9] == 1'b1) begin
              tx_q.push_back(int'(fr[8:1]));
              tx_t.push_back(first);
            end else begin
              tx_bad++;
            end
          end
        end
        prev = tx_o;
      end
    end
  end

  initial begin : disp_monitor
    logic [7:0] pdisp;
    pdisp = 8'h00;
    forever begin
      @(negedge clk);
      if (display_o !== pdisp) begin
        disp_t = cyc;
        pdisp = display_o;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx_i = 1'b0;
    repeat (10) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (10) @(posedge clk); #1;
    end
    rx_i = stop;
    repeat (10) @(posedge clk); #1;
    rx_i = 1'b1;
  endtask

  task automatic wait_q(input int n, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_disp(input logic [7:0] b, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (display_o === b) break;
    end
  endtask

  function automatic logic [7:0] pick_byte(input logic [7:0] avoid);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == avoid || b == 8'h3C || b == 8'h5A)
      b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic test_reset;
    bit ok;
    int bad_disp;
    int bad_idle;
    int seen_low;
    reset_i = 1'b0;
    rx_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (display_o !== 8'h00) begin
      fails++; $display("FAIL reset_display: got %h want 00", display_o);
    end
    tests++;
    if (tx_o !== 1'b1) begin
      fails++; $display("FAIL reset_tx: got %b want 1", tx_o);
    end
    @(posedge clk); #1;
    reset_i = 1'b1;
    tx_q.delete(); tx_t.delete();
    seen_low = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) seen_low = 1;
    end
    tests++;
    if (seen_low != 1) begin
      fails++; $display("FAIL banner_start_latency: start bit seen=%0d want 1 within 2 cycles", seen_low);
    end
    bad_disp = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (display_o !== 8'h00) bad_disp++;
    end
    wait_q(4, 10, ok);
    tests++;
    if (!ok || bad_disp != 0) begin
      fails++; $display("FAIL banner_count: frames=%0d bad_display_cycles=%0d want 4 and 0", tx_q.size(), bad_disp);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= tx_q.size() || tx_q[i] != banner[i]) begin
        fails++;
        $display("FAIL banner_byte%0d: got %h want %h", i, (i < tx_q.size()) ? tx_q[i] : -1, banner[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i + 1 >= tx_t.size() || tx_t[i+1] - tx_t[i] != 100) begin
        fails++;
        $display("FAIL banner_gap%0d: spacing %0d want 100", i, (i + 1 < tx_t.size()) ? tx_t[i+1] - tx_t[i] : -1);
      end
    end
    bad_idle = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) bad_idle++;
    end
    tests++;
    if (bad_idle != 0 || tx_q.size() != 4 || tx_bad != 0) begin
      fails++; $display("FAIL banner_idle: low_cycles=%0d frames=%0d bad=%0d want 0,4,0", bad_idle, tx_q.size(), tx_bad);
    end
  endtask

  task automatic test_echo;
    logic [7:0] b;
    int nq;
    int lat;
    bit ok;
    for (int n = 0; n < 5; n++) begin
      b = (n == 0) ? 8'hA5 : pick_byte(exp_disp);
      nq = tx_q.size();
      send_byte(b, 1'b1);
      wait_disp(b, 30);
      exp_disp = b;
      tests++;
      if (display_o !== exp_disp) begin
        fails++; $display("FAIL echo_display%0d: got %h want %h", n, display_o, exp_disp);
      end
      wait_q(nq + 1, 150, ok);
      tests++;
      if (!ok || tx_q[nq] != int'(b)) begin
        fails++; $display("FAIL echo_byte%0d: got %h want %h", n, ok ? tx_q[nq] : -1, b);
      end else begin
        lat = tx_t[nq] - disp_t;
        tests++;
        if (lat < 0 || lat > 2) begin
          fails++; $display("FAIL echo_latency%0d: got %0d cycles want 0..2", n, lat);
        end
      end
    end
  endtask

  task automatic test_frame_err;
    int nq;
    bit ok;
    nq = tx_q.size();
    send_byte(8'h3C, 1'b0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    tests++;
    if (display_o !== exp_disp || tx_q.size() != nq) begin
      fails++; $display("FAIL frame_err: display %h frames %0d want %h %0d", display_o, tx_q.size(), exp_disp, nq);
    end
    send_byte(8'h5A, 1'b1);
    wait_disp(8'h5A, 30);
    exp_disp = 8'h5A;
    tests++;
    if (display_o !== exp_disp) begin
      fails++; $display("FAIL frame_recover_display: got %h want %h", display_o, exp_disp);
    end
    wait_q(nq + 1, 150, ok);
    tests++;
    if (!ok || tx_q[nq] != 8'h5A) begin
      fails++; $display("FAIL frame_recover_echo: got %h want 5a", ok ? tx_q[nq] : -1);
    end
  endtask

  task automatic test_glitch;
    int nq;
    nq = tx_q.size();
    @(posedge clk); #1;
    rx_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx_i = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    tests++;
    if (display_o !== exp_disp || tx_q.size() != nq) begin
      fails++; $display("FAIL glitch: display %h frames %0d want %h %0d", display_o, tx_q.size(), exp_disp, nq);
    end
  endtask

  task automatic test_banner_rx;
    bit ok;
    @(posedge clk); #1;
    reset_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_i = 1'b1;
    tx_q.delete(); tx_t.delete();
    exp_disp = 8'h00;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_disp(8'h22, 30);
    exp_disp = 8'h22;
    tests++;
    if (display_o !== exp_disp) begin
      fails++; $display("FAIL banner_rx_display: got %h want %h", display_o, exp_disp);
    end
    wait_q(5, 700, ok);
    repeat (250) @(posedge clk);
    @(negedge clk);
    tests++;
    if (tx_q.size() != 5) begin
      fails++; $display("FAIL banner_rx_frames: got %0d want 5", tx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (tx_q[i] != ((i < 4) ? banner[i] : 8'h22)) begin
          fails++; $display("FAIL banner_rx_byte%0d: got %h want %h", i, tx_q[i], (i < 4) ? banner[i] : 8'h22);
        end
      end
      tests++;
      if (tx_t[4] - tx_t[3] != 100) begin
        fails++; $display("FAIL banner_rx_gap: got %0d want 100", tx_t[4] - tx_t[3]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int low;
    bit ok;
    b = pick_byte(exp_disp);
    send_byte(b, 1'b1);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        low = 1;
        break;
      end
    end
    tests++;
    if (low != 1) begin
      fails++; $display("FAIL reset_mid_echo_start: echo seen=%0d want 1", low);
    end
    repeat (35) @(posedge clk);
    #3;
    reset_i = 1'b0;
    #1;
    tests++;
    if (tx_o !== 1'b1 || display_o !== 8'h00) begin
      fails++; $display("FAIL reset_mid_abort: tx %b display %h want 1 00", tx_o, display_o);
    end
    repeat (2) @(posedge clk); #1;
    reset_i = 1'b1;
    tx_q.delete(); tx_t.delete();
    exp_disp = 8'h00;
    wait_q(4, 500, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL reset_mid_banner: frames %0d want 4", tx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (tx_q[i] != banner[i]) begin
          fails++; $display("FAIL reset_mid_byte%0d: got %h want %h", i, tx_q[i], banner[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_echo;
    test_frame_err;
    test_glitch;
    test_banner_rx;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc.md
SOC -- requirements
Module: soc

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD (integer division, 868 by default).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 display_o  output  8  registered display byte (last valid received byte).
REQ-006 rx_i  input  1  UART receive line, 8N1, idle high.
REQ-007 tx_o  output  1  UART transmit line, 8N1, idle high, registered.

Function
REQ-008 rx_i SHALL pass through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-009 RX idle: a synchronized 1->0 transition starts a frame; at CLKS_PER_BIT/2 cycles later the line is re-sampled; if high, the start is a glitch and RX returns to idle.
REQ-010 RX SHALL then sample 8 data bits LSB first, each CLKS_PER_BIT cycles apart at mid-bit, then the stop bit one bit-time later.
REQ-011 Stop bit = 1: byte is valid; display_o <= byte on the cycle after the stop sample and the byte is written to a 1-entry echo holding register.
REQ-012 Stop bit = 0: framing error; byte discarded, display_o and holding register unchanged; RX waits for line high before re-arming.
REQ-013 Holding register full when a new valid byte arrives: new byte overwrites (latest wins); the older byte is lost.
REQ-014 TX frame: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-015 TX SHALL accept the next byte on the cycle after its stop bit ends, so back-to-back frames have no idle gap.
REQ-016 Control FSM states: BANNER, ECHO. After reset release it enters BANNER and transmits 0x4F, 0x4B, 0x0D, 0x0A ("OK\r\n") in order, then enters ECHO permanently.
REQ-017 In ECHO, whenever TX is idle and the holding register is full, the byte is loaded into TX and the register cleared in the same cycle.
REQ-018 Bytes received during BANNER SHALL be shown on display_o immediately and echoed after the banner completes (subject to REQ-013).
REQ-019 Simultaneous valid-RX write and TX load in one cycle: the new RX byte is kept (register stays full with the new byte).
REQ-020 RX and TX operate fully independently (full duplex).

Reset
REQ-021 While reset_i = 0: display_o = 0x00, tx_o = 1, synchronizer flops = 1, RX/TX idle, counters 0, holding register empty, FSM = BANNER with banner index 0.
REQ-022 Reset asserted mid-frame aborts RX and TX immediately (tx_o = 1 in the same cycle as assertion); after release the banner restarts from 0x4F.
REQ-023 The first banner start bit SHALL appear on tx_o no later than 2 cycles after reset_i deasserts.

Structure
REQ-024 Package soc_pkg holds the banner byte constants, banner length (4) and the FSM state enum.
REQ-025 One sub-module, soc_uart, contains the RX (including synchronizer) and TX engines with CLKS_PER_BIT parameter, exposing rx_data/rx_valid/rx_frame_err and tx_data/tx_start/tx_busy; soc holds the FSM, holding register and display register.

Verification
Benches use CLK_FREQ_HZ = 1_000_000, BAUD = 100_000 (10 cycles/bit), 10 ns clock, and drive rx_i = 1 when unused.
REQ-026 Reset held 2 cycles, rx_i idle -> display_o = 0x00 throughout; tx_o emits 0x4F,0x4B,0x0D,0x0A back-to-back (400 cycles) then stays 1.
REQ-027 After the banner, send 0xA5 on rx_i -> display_o = 0xA5 one cycle after stop sample; tx_o echoes 0xA5 starting within 2 cycles.
REQ-028 Send 0x3C with stop bit 0 -> display_o keeps its prior value, no echo frame; then a valid 0x5A is displayed and echoed.
REQ-029 Send 0x11 then 0x22 during the banner -> display_o ends 0x22; after 0x0A exactly one echo frame 0x22 follows.
REQ-030 rx_i low pulse of 3 cycles -> no byte, display_o unchanged; assert reset_i mid-TX-frame -> tx_o = 1 at once, banner restarts with 0x4F after release.
